// File: rtl/ram_sync_sweep.sv
// Single-clock word RAM: registered read port, byte-lane write port, access-error pulse and a
// hardware clear sweep over [CLR_LO, CLR_HI]. Optional macro RAM_FWD_EN forwards same-address write data to the read port.
module ram_sync_sweep #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int CLR_LO = 0,
    parameter int CLR_HI = DEPTH - 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                init_req,
    output logic                busy,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                err
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PTR_LO = ADDR_W'(CLR_LO);
    localparam logic [ADDR_W-1:0] PTR_HI = ADDR_W'(CLR_HI);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_clr_we;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_rd_oor;
    logic              w_wr_oor;
    logic              w_rd_acc;
    logic              w_wr_ok;
    logic              w_err_nxt;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_nxt;

    logic [DATA_W-1:0] r_rd_data_p1;
    logic              r_rd_vld_p1;
    logic              r_err_p1;

    // Byte-lane merge: lanes with be[k] set take new_w, the rest keep old_w.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) m[8*k +: 8] = new_w[8*k +: 8];
        end
        return m;
    endfunction

    // Sweep controller: one word zeroed per cycle, leaves CLEAR on the edge that writes CLR_HI.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_clr_we    = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we  = 1'b1;
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == PTR_HI) w_state_nxt = IDLE;
            end
            default: begin
                if (init_req) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = PTR_LO;
                end
            end
        endcase
    end

    assign busy     = (r_state == CLEAR);
    assign w_rd_oor = (32'(rd_addr) >= DEPTH);
    assign w_wr_oor = (32'(wr_addr) >= DEPTH);
    assign w_rd_acc = ~busy & rd_en;
    assign w_wr_ok  = ~busy & wr_en & ~w_wr_oor;

    // A locked-out cycle and an out-of-range cycle both collapse into one error pulse.
    assign w_err_nxt = busy ? (rd_en | wr_en)
                            : ((rd_en & w_rd_oor) | (wr_en & w_wr_oor));

    always_comb begin
        w_rd_word = r_mem[rd_addr];
`ifdef RAM_FWD_EN
        if (w_wr_ok && (wr_addr == rd_addr)) w_rd_word = merge_lanes(w_rd_word, wr_data, wr_be);
`endif
        w_rd_nxt = w_rd_oor ? '0 : w_rd_word;
    end

    // ---- stage p1: registered read result, valid and error ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= CLEAR;
            r_ptr        <= PTR_LO;
            r_rd_data_p1 <= '0;
            r_rd_vld_p1  <= 1'b0;
            r_err_p1     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_rd_vld_p1 <= w_rd_acc;
            r_err_p1    <= w_err_nxt;
            if (w_rd_acc) r_rd_data_p1 <= w_rd_nxt;
        end
    end

    // Array storage has no reset; the sweep is the only bulk initialisation.
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= merge_lanes(r_mem[wr_addr], wr_data, wr_be);
        end
    end

    assign rd_data  = r_rd_data_p1;
    assign rd_valid = r_rd_vld_p1;
    assign err      = r_err_p1;

endmodule
